// File: rtl/keypad_scanner_pkg.sv
// Shared constants and types for the keypad scanner.
//   NUM_COLS / NUM_ROWS : keypad matrix dimensions
//   KEY_CODE_W          : width of key_code (col_index*4 + row_index)
//   state_e             : debounce FSM states
//   scan_res_e          : classification of one full column scan
package keypad_scanner_pkg;

  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCandidate,
    StPressed,
    StReleasing
  } state_e;

  typedef enum logic [1:0] {
    ScanNone,
    ScanSingle,
    ScanMulti
  } scan_res_e;

endpackage

// File: rtl/keypad_sync.sv
// Two-stage synchronizer for asynchronous inputs; flops reset to all ones
// (idle level of the active-low row lines).
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
module keypad_sync
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned Width = NUM_ROWS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-based press/release debounce.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   scan_tick_i : one-clk strobe that samples the current column and advances it
//   row_i       : active-low row lines (asynchronous)
//   col_o       : active-low column drive, exactly one bit low
//   key_code_o  : code of the accepted key (col*4 + row), held between presses
//   key_valid_o : one-clk pulse on debounced press acceptance
//   key_down_o  : high from acceptance until debounced release
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scan_tick_i,
  input  logic [NUM_ROWS-1:0]   row_i,
  output logic [NUM_COLS-1:0]   col_o,
  output logic [KEY_CODE_W-1:0] key_code_o,
  output logic                  key_valid_o,
  output logic                  key_down_o
);

  localparam logic [3:0] DebN = 4'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] rs;

  keypad_sync #(
    .Width(NUM_ROWS)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (row_i),
    .q_o  (rs)
  );

  logic [1:0]            col_q;
  scan_res_e             acc_res_q, acc_res_d;
  logic [KEY_CODE_W-1:0] acc_code_q, acc_code_d;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_down_q, key_down_d;

  logic [2:0]            low_cnt;
  logic [1:0]            low_idx;
  scan_res_e             scan_res;
  logic [KEY_CODE_W-1:0] scan_code;
  logic                  eval;

  assign col_o = ~(4'b0001 << col_q);
  assign eval  = scan_tick_i && (col_q == 2'd3);

  // Fold the current column's rows into the running scan result; this is the
  // full-scan result when the last column is being sampled.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!rs[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_idx = 2'(i);
      end
    end
    scan_res  = acc_res_q;
    scan_code = acc_code_q;
    if (low_cnt == 3'd1) begin
      if (acc_res_q == ScanNone) begin
        scan_res  = ScanSingle;
        scan_code = {col_q, low_idx};
      end else begin
        scan_res = ScanMulti;
      end
    end else if (low_cnt > 3'd1) begin
      scan_res = ScanMulti;
    end
    acc_res_d  = acc_res_q;
    acc_code_d = acc_code_q;
    if (scan_tick_i) begin
      acc_res_d  = eval ? ScanNone : scan_res;
      acc_code_d = eval ? '0 : scan_code;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (eval) begin
      unique case (state_q)
        StIdle: begin
          if (scan_res == ScanSingle) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
            if (DebN == 4'd1) begin
              state_d     = StPressed;
              key_code_d  = scan_code;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              state_d = StCandidate;
            end
          end
        end
        StCandidate: begin
          if (scan_res == ScanSingle) begin
            if (scan_code == cand_q) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == DebN) begin
                state_d     = StPressed;
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
                key_down_d  = 1'b1;
              end
            end else begin
              cand_d = scan_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StPressed: begin
          if (scan_res == ScanNone) begin
            cnt_d = 4'd1;
            if (DebN == 4'd1) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end else begin
              state_d = StReleasing;
            end
          end
        end
        StReleasing: begin
          if (scan_res == ScanNone) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DebN) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end
          end else begin
            // Bounce during release: back to held, no new key_valid.
            state_d = StPressed;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q       <= 2'd0;
      acc_res_q   <= ScanNone;
      acc_code_q  <= '0;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      if (scan_tick_i) col_q <= col_q + 2'd1;
      acc_res_q   <= acc_res_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_down_o  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_tick = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [15:0] keys = 16'h0000;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .DEBOUNCE_SCANS(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scan_tick_i(scan_tick),
    .row_i      (row),
    .col_o      (col),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_down_o (key_down)
  );

  // Key matrix: pressed key c*4+r pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) row[r] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (key_valid) valid_cnt <= valid_cnt + 1;

  task automatic tick();
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One full scan (c = 0..3) with the given key set; reports key_valid just
  // after the evaluating tick and one clk later.
  task automatic scan(input logic [15:0] k, output logic v_eval, output logic v_next);
    keys = k;
    v_eval = 1'b0;
    v_next = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      if (c == 3) v_eval = key_valid;
      @(negedge clk);
      if (c == 3) v_next = key_valid;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b expected 1110", col); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL reset_down: got %b expected 0", key_down); end
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    n_vec++; if (col !== 4'b1110) begin n_err++; $display("FAIL tick_in_reset_col: got %b expected 1110", col); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col [4];
    exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (col !== exp_col[i]) begin
        n_err++; $display("FAIL idle_col%0d: got %b expected %b", i, col, exp_col[i]);
      end
    end
    n_vec++; if (valid_cnt !== 0) begin n_err++; $display("FAIL idle_valid_cnt: got %0d expected 0", valid_cnt); end
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL idle_down: got %b expected 0", key_down); end
  endtask

  task automatic release_clean();
    logic ve, vn;
    for (int s = 0; s < 4; s++) scan(16'h0000, ve, vn);
  endtask

  task automatic test_single_press();
    logic ve, vn;
    int base;
    base = valid_cnt;
    for (int s = 1; s <= 5; s++) begin
      scan(16'h0040, ve, vn);
      n_vec++;
      if (ve !== (s == 4)) begin
        n_err++; $display("FAIL press6_eval_scan%0d: got %b expected %b", s, ve, (s == 4));
      end
      if (s == 4) begin
        n_vec++; if (vn !== 1'b0) begin n_err++; $display("FAIL press6_pulse_width: got %b expected 0", vn); end
      end
    end
    n_vec++; if (valid_cnt - base !== 1) begin n_err++; $display("FAIL press6_pulses: got %0d expected 1", valid_cnt - base); end
    n_vec++; if (key_code !== 4'd6) begin n_err++; $display("FAIL press6_code: got %0d expected 6", key_code); end
    n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL press6_down: got %b expected 1", key_down); end
    for (int s = 1; s <= 4; s++) begin
      scan(16'h0000, ve, vn);
      n_vec++;
      if (key_down !== (s < 4)) begin
        n_err++; $display("FAIL release6_down_scan%0d: got %b expected %b", s, key_down, (s < 4));
      end
    end
  endtask

  task automatic test_interrupted();
    logic ve, vn;
    int base;
    base = valid_cnt;
    for (int s = 0; s < 3; s++) scan(16'h0040, ve, vn);
    scan(16'h0000, ve, vn);
    n_vec++; if (valid_cnt !== base) begin n_err++; $display("FAIL interrupt_early: got %0d expected %0d", valid_cnt, base); end
    for (int s = 1; s <= 4; s++) begin
      scan(16'h0040, ve, vn);
      n_vec++;
      if (ve !== (s == 4)) begin
        n_err++; $display("FAIL interrupt_eval_scan%0d: got %b expected %b", s, ve, (s == 4));
      end
    end
    n_vec++; if (valid_cnt - base !== 1) begin n_err++; $display("FAIL interrupt_pulses: got %0d expected 1", valid_cnt - base); end
    release_clean();
  endtask

  task automatic test_multi();
    logic ve, vn;
    int base;
    base = valid_cnt;
    for (int s = 0; s < 5; s++) scan(16'h0240, ve, vn);
    n_vec++; if (valid_cnt !== base) begin n_err++; $display("FAIL multi_no_valid: got %0d expected %0d", valid_cnt, base); end
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL multi_down: got %b expected 0", key_down); end
    for (int s = 1; s <= 4; s++) begin
      scan(16'h0040, ve, vn);
      n_vec++;
      if (ve !== (s == 4)) begin
        n_err++; $display("FAIL multi_release9_scan%0d: got %b expected %b", s, ve, (s == 4));
      end
    end
    n_vec++; if (key_code !== 4'd6) begin n_err++; $display("FAIL multi_code: got %0d expected 6", key_code); end
  endtask

  // Entered with key 6 accepted and held.
  task automatic test_release_bounce();
    logic ve, vn;
    logic [15:0] pat [6];
    logic        exp_down [6];
    int base;
    pat      = '{16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_down = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    base = valid_cnt;
    for (int s = 0; s < 6; s++) begin
      scan(pat[s], ve, vn);
      n_vec++;
      if (key_down !== exp_down[s]) begin
        n_err++; $display("FAIL bounce_down_scan%0d: got %b expected %b", s, key_down, exp_down[s]);
      end
    end
    n_vec++; if (valid_cnt !== base) begin n_err++; $display("FAIL bounce_extra_valid: got %0d expected %0d", valid_cnt, base); end
  endtask

  task automatic test_codes();
    logic ve, vn;
    for (int s = 0; s < 4; s++) scan(16'h8000, ve, vn);
    n_vec++; if (key_code !== 4'd15) begin n_err++; $display("FAIL code15: got %0d expected 15", key_code); end
    release_clean();
    for (int s = 0; s < 4; s++) scan(16'h0001, ve, vn);
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL code0: got %0d expected 0", key_code); end
    release_clean();
  endtask

  task automatic test_reset_mid();
    logic ve, vn;
    int base;
    base = valid_cnt;
    scan(16'h0040, ve, vn);
    scan(16'h0040, ve, vn);
    tick();
    tick();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    keys = 16'h0000;
    n_vec++; if (col !== 4'b1110) begin n_err++; $display("FAIL rstmid_col: got %b expected 1110", col); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL rstmid_code: got %0d expected 0", key_code); end
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL rstmid_down: got %b expected 0", key_down); end
    release_clean();
    n_vec++; if (valid_cnt !== base) begin n_err++; $display("FAIL rstmid_valid: got %0d expected %0d", valid_cnt, base); end
    // Reset while a key is held down.
    for (int s = 0; s < 4; s++) scan(16'h0040, ve, vn);
    n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL rstpress_pre_down: got %b expected 1", key_down); end
    keys = 16'h0000;
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL rstpress_down: got %b expected 0", key_down); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL rstpress_code: got %0d expected 0", key_code); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_scan();
    test_single_press();
    test_interrupted();
    test_multi();
    test_release_bounce();
    test_codes();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_SCANS, default 4, number of consecutive identical full scans required to accept a press or a release; legal range 1..15.
REQ-002 clk  input  1  system clock; the only clock in the block.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 scan_tick  input  1  one-clk strobe that advances the column scan; it SHALL be no more often than one per 4 clk.
REQ-005 row  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  position code of the accepted key, col_index*4 + row_index; held between presses.
REQ-008 key_valid  output  1  one-clk pulse when a debounced press is accepted.
REQ-009 key_down  output  1  level, high from acceptance until debounced release.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before use; the synchronized value is called rs.
REQ-011 A column index c (0..3) SHALL drive col = ~(1<<c); on each scan_tick the block samples rs for column c, then c advances as c = (c+1) mod 4 in the same clk.
REQ-012 Within one scan (c = 0..3), the block SHALL record: none, single (exactly one low bit in exactly one column), or multi (any other combination); the code is c*4 + row bit index.
REQ-013 Scan evaluation SHALL occur on the scan_tick that samples c = 3; the scan accumulator then clears for the next scan.
REQ-014 FSM states: IDLE, CANDIDATE, PRESSED, RELEASING; a counter cnt (4 bits) counts consecutive matching scans.
REQ-015 IDLE: single → CANDIDATE with cand = code and cnt = 1, or directly → PRESSED if DEBOUNCE_SCANS = 1; none or multi → stay.
REQ-016 CANDIDATE: single with the same code → cnt+1; when cnt reaches DEBOUNCE_SCANS → PRESSED.
REQ-017 CANDIDATE: a different single code SHALL restart with cand = new code and cnt = 1; none or multi → IDLE.
REQ-018 On entry to PRESSED: key_code = cand, key_down = 1, and key_valid = 1 for exactly the next clk only.
REQ-019 PRESSED: none → RELEASING with cnt = 1, or directly → IDLE if DEBOUNCE_SCANS = 1; single or multi → stay (no rollover, no second key_valid).
REQ-020 RELEASING: none → cnt+1; when cnt reaches DEBOUNCE_SCANS → IDLE and key_down = 0; any key → PRESSED with no key_valid.
REQ-021 Latency: key_valid SHALL rise one clk after the evaluating scan_tick of the DEBOUNCE_SCANS-th matching scan.
REQ-022 scan_tick asserted while rst is high SHALL be ignored.

Reset
REQ-023 On rst: c = 0, col = 4'b1110, synchronizer flops = 4'b1111, accumulator cleared, FSM = IDLE, cnt = 0, cand = 0, key_code = 0, key_valid = 0, key_down = 0.
REQ-024 Reset mid-debounce or mid-press SHALL abandon it with no key_valid pulse, and key_down SHALL drop on the next clk.

Structure
REQ-025 Shared package/include SHALL hold NUM_COLS = 4, NUM_ROWS = 4, the FSM state encodings, and the key_code width.
REQ-026 The synchronizer SHALL be a sub-module named keypad_sync (parameterized width, 2 stages, reset to all ones).

Verification
REQ-027 Reset, then scan_tick every 4 clk with no keys → col cycles 1110, 1101, 1011, 0111, 1110; key_valid and key_down never assert.
REQ-028 Hold row = 1011 only while col = 1101 for 5 scans → exactly one key_valid pulse, key_code = 6, key_valid one clk after the 4th scan's c = 3 tick.
REQ-029 Key 6 pressed for 3 scans, absent for 1 scan, then pressed for 4 scans → one key_valid, after the second run only.
REQ-030 Keys 6 and 9 held together → no key_valid; release key 9 → key_valid with key_code = 6 after 4 scans.
REQ-031 After acceptance, a release with a 1-scan bounce (none, key, none×4) → key_down stays 1 through the bounce, falls after the 4th clean none scan, and no extra key_valid.
REQ-032 Assert rst during the 3rd matching scan → key_valid never asserts for that press and all outputs match REQ-023.
